// File: rtl/inv_perm_chi_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
// Shared definitions for the iterative inverse-chi block:
//   - state geometry (X_AXIS x Y_AXIS x Z_AXIS) and slice grouping
//   - state_t : full state, indexed [x][y][z]
//   - row_t   : one 5-bit chi row, bit x <-> lane x
//   - chi_row : forward chi on a single row
//   - CHI_INV : 32-entry inverse table, built at elaboration by searching chi_row
//   - fsm_t   : controller states
// -----------------------------------------------------------------------------
package keccak_pkg;

  localparam int X_AXIS = 5;
  localparam int Y_AXIS = 5;
  localparam int Z_AXIS = 64;
  localparam int SLICES = 8;
  localparam int GROUPS = Z_AXIS / SLICES;

  typedef logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] state_t;
  typedef logic [4:0] row_t;
  typedef logic [31:0][4:0] chi_tab_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  // Forward chi on one row: b[x] = a[x] ^ (~a[x+1] & a[x+2]), indices mod 5.
  function automatic row_t chi_row(input row_t a);
    row_t b;
    b = 5'd0;
    for (int x = 0; x < 5; x++) begin
      b[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
    end
    return b;
  endfunction

  // chi is a bijection on 5 bits, so writing every pre-image at the index of
  // its image fills the whole inverse table exactly once.
  function automatic chi_tab_t gen_chi_inv();
    chi_tab_t t;
    t = '0;
    for (int a = 0; a < 32; a++) begin
      t[chi_row(5'(a))] = 5'(a);
    end
    return t;
  endfunction

  localparam chi_tab_t CHI_INV = gen_chi_inv();

endpackage

// File: rtl/inv_perm_chi_if.sv
// -----------------------------------------------------------------------------
// inv_perm_chi_if
// Handshake bundle for inv_perm_chi.
//   in_valid/in_ready/b_in      : chi-output state offered to the block
//   out_valid/out_ready/a_out   : recovered chi-input state
//   busy                        : block is iterating over slice groups
// slave modport is the block side, master modport the producer/consumer side.
// -----------------------------------------------------------------------------
interface inv_perm_chi_if;
  import keccak_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t b_in;
  logic   out_valid;
  logic   out_ready;
  state_t a_out;
  logic   busy;

  modport slave (
    input  in_valid, b_in, out_ready,
    output in_ready, out_valid, a_out, busy
  );

  modport master (
    output in_valid, b_in, out_ready,
    input  in_ready, out_valid, a_out, busy
  );

endinterface

// File: rtl/inv_perm_chi_slice.sv
// -----------------------------------------------------------------------------
// chi_inv_slice
// Combinational inverse chi for one z-slice (Y_AXIS rows of 5 bits).
//   b_rows : chi-output rows of the slice, row y bit x <-> lane x
//   a_rows : chi-input rows recovered through CHI_INV
// -----------------------------------------------------------------------------
module chi_inv_slice
  import keccak_pkg::*;
(
  input  row_t [Y_AXIS-1:0] b_rows,
  output row_t [Y_AXIS-1:0] a_rows
);

  // Per-row table lookup of the chi pre-image.
  always_comb begin
    a_rows = '0;
    for (int y = 0; y < Y_AXIS; y++) begin
      a_rows[y] = CHI_INV[b_rows[y]];
    end
  end

endmodule

// File: rtl/inv_perm_chi.sv
// -----------------------------------------------------------------------------
// inv_perm_chi
// Slice-serial inverse of Keccak chi. A state is captured in IDLE, then SLICES
// z-slices are inverted in place per cycle for GROUPS cycles (BUSY), and the
// result is held on a_out while out_valid is high (DONE).
//   clk, rst : single clock, synchronous active-high reset
//   bus      : inv_perm_chi_if.slave (in/out handshakes, b_in, a_out, busy)
// -----------------------------------------------------------------------------
module inv_perm_chi
  import keccak_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  inv_perm_chi_if.slave  bus
);

  localparam int ZW    = (Z_AXIS > 1) ? $clog2(Z_AXIS) : 1;
  localparam int GRP_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);

  if (X_AXIS != 5) begin : g_bad_x
    $error("inv_perm_chi: chi is only defined for X_AXIS == 5");
  end
  if ((Z_AXIS % SLICES) != 0) begin : g_bad_slices
    $error("inv_perm_chi: SLICES must divide Z_AXIS");
  end

  fsm_t             state_r;
  state_t           st_r;
  logic [GRP_W-1:0] grp_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [ZW-1:0]                 base_s;
  row_t [SLICES-1:0][Y_AXIS-1:0] slice_in_s;
  row_t [SLICES-1:0][Y_AXIS-1:0] slice_out_s;

  // Gather the rows of the grp-selected slice group out of the working state.
  always_comb begin
    base_s     = ZW'(int'(grp_r) * SLICES);
    slice_in_s = '0;
    for (int s = 0; s < SLICES; s++) begin
      for (int y = 0; y < Y_AXIS; y++) begin
        for (int x = 0; x < X_AXIS; x++) begin
          slice_in_s[s][y][x] = st_r[x][y][base_s + ZW'(s)];
        end
      end
    end
  end

  for (genvar s = 0; s < SLICES; s++) begin : g_slice
    chi_inv_slice u_slice (
      .b_rows (slice_in_s[s]),
      .a_rows (slice_out_s[s])
    );
  end

  // Controller, working state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      st_r        <= '0;
      grp_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            st_r       <= bus.b_in;
            grp_r      <= '0;
            state_r    <= ST_BUSY;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        ST_BUSY: begin
          // Write the inverted slice group back in place.
          for (int s = 0; s < SLICES; s++) begin
            for (int y = 0; y < Y_AXIS; y++) begin
              for (int x = 0; x < X_AXIS; x++) begin
                st_r[x][y][base_s + ZW'(s)] <= slice_out_s[s][y][x];
              end
            end
          end
          if (grp_r == GRP_LAST) begin
            grp_r       <= '0;
            state_r     <= ST_DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            grp_r <= grp_r + GRP_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          grp_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.a_out     = st_r;

endmodule
